// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcode field, HALT opcode and fetch-stage state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;

  localparam opcode_t HALT = 6'h3F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  function automatic opcode_t op_of(input word_t w);
    return w[31:26];
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer holding a fetched word and its PC+4 while decode is stalled.
module fetch_hold_buf
  import cpu_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic        rel,
  input  logic [31:0] instr_in,
  input  logic [31:0] npc_in,
  output logic [31:0] instr,
  output logic [31:0] npc,
  output logic        valid
);

  word_t instr_q, instr_d;
  word_t npc_q, npc_d;
  logic  valid_q, valid_d;

  // clear beats load so a redirect in the capture cycle leaves the buffer empty
  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (clear || rel) begin
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      npc_d   = npc_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign npc   = npc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to the icache, absorbs decode stalls,
// accepts redirects and parks after delivering a HALT.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = HALT
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_src,
  output logic        ifid_wen,
  output logic        halted
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  word_t        pc_src_q, pc_src_d;
  logic         ifid_wen_q, ifid_wen_d;

  logic  buf_load, buf_clear, buf_rel, buf_valid;
  word_t buf_instr, buf_npc;
  word_t pc_plus4;
  logic  unused_redirect_lsb;

  assign pc_plus4            = pc_q + 32'd4;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  fetch_hold_buf u_hold (
    .clk      (CLK),
    .rst      (RST),
    .load     (buf_load),
    .clear    (buf_clear),
    .rel      (buf_rel),
    .instr_in (imemload),
    .npc_in   (pc_plus4),
    .instr    (buf_instr),
    .npc      (buf_npc),
    .valid    (buf_valid)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_src_d   = pc_src_q;
    ifid_wen_d = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    buf_rel    = 1'b0;

    if (redirect) begin
      // any ihit this cycle is dropped; the PC restarts at the target
      pc_d      = {redirect_pc[31:2], 2'b00};
      buf_clear = 1'b1;
      state_d   = FETCH;
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (ihit) begin
            pc_d = pc_plus4;
            if (!stall) begin
              instr_d    = imemload;
              pc_src_d   = pc_plus4;
              ifid_wen_d = 1'b1;
              if (op_of(imemload) == HALT_OP) state_d = HALTED;
            end else begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall && buf_valid) begin
            instr_d    = buf_instr;
            pc_src_d   = buf_npc;
            ifid_wen_d = 1'b1;
            buf_rel    = 1'b1;
            state_d    = (op_of(buf_instr) == HALT_OP) ? HALTED : FETCH;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      pc_q       <= PC_INIT;
      instr_q    <= '0;
      pc_src_q   <= '0;
      ifid_wen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_src_q   <= pc_src_d;
      ifid_wen_q <= ifid_wen_d;
    end
  end

  assign imemREN     = (state_q == FETCH) && !RST;
  assign imemaddr    = pc_q;
  assign instruction = instr_q;
  assign pc_src      = pc_src_q;
  assign ifid_wen    = ifid_wen_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of the fetch rules.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instruction;
  logic [31:0] pc_src;
  logic        ifid_wen;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_INIT(32'h0000_0000), .HALT_OP(6'h3F)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
    .imemload(imemload), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instruction(instruction), .pc_src(pc_src), .ifid_wen(ifid_wen), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // Reference: program memory plus the externally visible fetch behaviour.
  // m_started: the first post-reset cycle has passed; m_parked: a HALT was delivered;
  // m_held: words fetched under stall and not yet delivered.
  logic [31:0] m_pc, m_instr, m_src;
  logic        m_wen, m_started, m_parked;
  logic [31:0] m_held_w[$];
  logic [31:0] m_held_n[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] w;
    if (a == 32'h0000_0200) return 32'hFC00_0000;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (w[7:4] == 4'h0) w[31:26] = 6'h3F;
    else if (w[31:26] == 6'h3F) w[31:26] = 6'h01;
    return w;
  endfunction

  function automatic logic is_halt(input logic [31:0] w);
    return w[31:26] == 6'h3F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_src = 32'h0; m_wen = 1'b0;
    m_started = 1'b0; m_parked = 1'b0;
    m_held_w.delete(); m_held_n.delete();
  endtask

  function automatic logic m_fetching();
    return m_started && !m_parked && m_held_w.size() == 0;
  endfunction

  task automatic model_step(input logic h, input logic s, input logic r, input logic [31:0] rp);
    logic [31:0] w;
    m_wen = 1'b0;
    if (r) begin
      m_pc = rp & 32'hFFFF_FFFC;
      m_held_w.delete(); m_held_n.delete();
      m_parked = 1'b0; m_started = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_parked) begin
      // parked until redirect or reset
    end else if (m_held_w.size() != 0) begin
      if (!s) begin
        m_instr = m_held_w.pop_front();
        m_src   = m_held_n.pop_front();
        m_wen   = 1'b1;
        m_parked = is_halt(m_instr);
      end
    end else if (h) begin
      w = memf(m_pc);
      if (!s) begin
        m_instr = w; m_src = m_pc + 32'd4; m_wen = 1'b1;
        m_parked = is_halt(w);
      end else begin
        m_held_w.push_back(w);
        m_held_n.push_back(m_pc + 32'd4);
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ren"},    {31'b0, imemREN},  {31'b0, m_fetching()});
    chk({tag, ".addr"},   imemaddr,          m_pc);
    chk({tag, ".wen"},    {31'b0, ifid_wen}, {31'b0, m_wen});
    chk({tag, ".instr"},  instruction,       m_instr);
    chk({tag, ".pcsrc"},  pc_src,            m_src);
    chk({tag, ".halted"}, {31'b0, halted},   {31'b0, m_parked && m_held_w.size() == 0});
  endtask

  // One clock: check at negedge, drive inputs, advance the model, wait for the edge.
  task automatic cyc(input string tag, input logic h, input logic s, input logic r,
                     input logic [31:0] rp);
    @(negedge CLK);
    check_outputs(tag);
    ihit = h; stall = s; redirect = r; redirect_pc = rp;
    imemload = h ? memf(m_pc) : 32'hDEAD_BEEF;
    model_step(h, s, r, rp);
    @(posedge CLK);
  endtask

  // Asynchronous reset applied between edges; outputs must drop without waiting for a clock.
  task automatic do_reset(input string tag);
    #2 RST = 1'b1;
    #1;
    model_reset();
    chk({tag, ".rst_ren"},   {31'b0, imemREN},  32'h0);
    chk({tag, ".rst_wen"},   {31'b0, ifid_wen}, 32'h0);
    chk({tag, ".rst_halt"},  {31'b0, halted},   32'h0);
    chk({tag, ".rst_instr"}, instruction,       32'h0);
    chk({tag, ".rst_pcsrc"}, pc_src,            32'h0);
    chk({tag, ".rst_addr"},  imemaddr,          32'h0);
    ihit = 1'b0; stall = 1'b0; redirect = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge CLK);
    do_reset("init");

    // stall-free stream from PC_INIT
    for (int i = 0; i < 5; i++) cyc("stream", 1'b1, 1'b0, 1'b0, 32'h0);

    // stall across a hit, then release
    cyc("hold", 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc("hold", 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc("hold", 1'b1, 1'b0, 1'b0, 32'h0);

    // redirect collides with ihit
    cyc("redir", 1'b1, 1'b0, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 2; i++) cyc("redir", 1'b1, 1'b0, 1'b0, 32'h0);

    // redirect collides with stall on a held word
    cyc("rdst", 1'b1, 1'b1, 1'b0, 32'h0);
    cyc("rdst", 1'b0, 1'b1, 1'b1, 32'h0000_0500);
    for (int i = 0; i < 2; i++) cyc("rdst", 1'b1, 1'b0, 1'b0, 32'h0);

    // HALT delivery, parking, resume by redirect
    cyc("halt", 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 5; i++) cyc("halt", 1'b1, 1'b0, 1'b0, 32'h0);
    cyc("halt", 1'b0, 1'b0, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 2; i++) cyc("halt", 1'b1, 1'b0, 1'b0, 32'h0);

    // HALT captured under stall, released afterwards
    cyc("hhold", 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    cyc("hhold", 1'b1, 1'b1, 1'b0, 32'h0);
    cyc("hhold", 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc("hhold", 1'b1, 1'b0, 1'b0, 32'h0);

    // PC wrap at the top of the address space
    cyc("wrap", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) cyc("wrap", 1'b1, 1'b0, 1'b0, 32'h0);

    // reset mid-FETCH (request outstanding) and mid-HOLD
    cyc("rstf", 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    cyc("rstf", 1'b0, 1'b0, 1'b0, 32'h0);
    do_reset("rstf");
    for (int i = 0; i < 3; i++) cyc("rstf", 1'b1, 1'b0, 1'b0, 32'h0);
    cyc("rsth", 1'b1, 1'b1, 1'b0, 32'h0);
    cyc("rsth", 1'b0, 1'b1, 1'b0, 32'h0);
    do_reset("rsth");
    for (int i = 0; i < 3; i++) cyc("rsth", 1'b1, 1'b0, 1'b0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic h, s, r;
      logic [31:0] rp;
      h = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       rp = 32'hFFFF_FFFC;
        1:       rp = 32'h0000_0200;
        default: rp = $urandom;
      endcase
      cyc("rand", h, s, r, rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
